counter: RTL and testbench

//  - Free-running synchronous up-counter with parameterisable width, step and wrap point.
//  - Drives a registered count value for sequencing, timestamps and bench stimulus.
//  - Single clock domain. Asynchronous active-low reset forces the count to a known start value.

---
 rtl/counter.sv | 61 ++++++
 tb/tb_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running up-counter with configurable width, step and wrap point; async assert / sync release reset.
// Optional macro COUNTER_SATURATE_EN: saturate at MAX_VALUE instead of wrapping modulo MAX_VALUE+1.
module counter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP        = 1,
  parameter int unsigned MAX_VALUE   = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VALUE = 0
) (
  output logic [WIDTH-1:0] value,
  input  logic             clk,
  input  logic             reset
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

  // Elaboration-time parameter legality checks
  if (WIDTH < 2) begin : g_bad_width
    $error("counter: WIDTH must be >= 2");
  end
  if (64'(MAX_VALUE) > LIMIT) begin : g_bad_max
    $error("counter: MAX_VALUE must fit in WIDTH bits");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $error("counter: STEP must satisfy 1 <= STEP <= MAX_VALUE");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("counter: RESET_VALUE must be <= MAX_VALUE");
  end

  logic [1:0]       sync;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] next_value;

  // Next count: one extra bit so the overflow compare never aliases
  always_comb begin
    sum        = {1'b0, value} + SUM_W'(STEP);
    next_value = WIDTH'(sum);
    if (sum > SUM_W'(MAX_VALUE)) begin
`ifdef COUNTER_SATURATE_EN
      next_value = WIDTH'(MAX_VALUE);
`else
      next_value = WIDTH'(sum - SUM_W'(MAX_VALUE) - SUM_W'(1));
`endif
    end
  end

  // sync[1] rises on the 2nd edge after release, so counting begins on the 3rd
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= 2'b00;
      value <= WIDTH'(RESET_VALUE);
    end else begin
      sync <= {sync[0], 1'b1};
      if (sync[1]) begin
        value <= next_value;
      end
    end
  end

endmodule

// File: tb/tb_counter.sv
// Randomised self-checking bench for counter: default instance plus a WIDTH=8/STEP=3/MAX_VALUE=9 instance.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk   = 1'b1;
  logic       reset = 1'b1;
  logic [7:0] value_a;
  logic [7:0] value_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: edges seen since release and expected counts
  int m_edges = 0;
  int m_a     = 0;
  int m_b     = 0;

  counter u_a (
    .value (value_a),
    .clk   (clk),
    .reset (reset)
  );

  counter #(
    .WIDTH     (8),
    .STEP      (3),
    .MAX_VALUE (9)
  ) u_b (
    .value (value_b),
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  function automatic int step_ref(input int v, input int step, input int maxv);
    if (v + step > maxv) return SAT ? maxv : v + step - (maxv + 1);
    return v + step;
  endfunction

  always @(negedge reset) begin
    m_edges = 0;
    m_a     = 0;
    m_b     = 0;
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      m_edges = m_edges + 1;
      if (m_edges >= 3) begin
        m_a = step_ref(m_a, 1, 255);
        m_b = step_ref(m_b, 3, 9);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check("run_a", 32'(value_a), 32'(m_a));
      check("run_b", 32'(value_b), 32'(m_b));
    end
  endtask

  // Called at a falling clk edge; asserts d units later, holds for h units
  task automatic pulse(input int d, input int h);
    #(d);
    reset = 1'b0;
    #1;
    check("rst_a", 32'(value_a), 32'd0);
    check("rst_b", 32'(value_b), 32'd0);
    #(h - 1);
    reset = 1'b1;
  endtask

  int seq_tbl [8];
  int d;
  int h;

  initial begin
    if (SAT) seq_tbl = '{0, 3, 6, 9, 9, 9, 9, 9};
    else     seq_tbl = '{0, 3, 6, 9, 2, 5, 8, 1};

    // Async assert with clk mid-low, no edge needed
    #17;
    reset = 1'b0;
    #1;
    check("async_a", 32'(value_a), 32'd0);
    check("async_b", 32'(value_b), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold_a", 32'(value_a), 32'd0);
    check("hold_b", 32'(value_b), 32'd0);

    // Release: two idle edges, count on the third
    #2;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_a", 32'(value_a), 32'd0);
    end
    @(negedge clk);
    check("first_a", 32'(value_a), 32'd1);
    check("first_b", 32'(value_b), 32'd3);
    cycles(9);
    check("ten_a", 32'(value_a), 32'd10);

    // Wrap (or saturate) at the top of the default range
    cycles(245);
    check("pre_wrap", 32'(value_a), 32'd255);
    cycles(1);
    check("wrap", 32'(value_a), SAT ? 32'd255 : 32'd0);
    cycles(1);
    check("post_wrap", 32'(value_a), SAT ? 32'd255 : 32'd1);
    cycles(20);
    check("after20", 32'(value_a), SAT ? 32'd255 : 32'd21);

    // Reset mid-count at value 5, held 11 time units
    pulse(1, 3);
    cycles(7);
    check("at5", 32'(value_a), 32'd5);
    pulse(2, 11);
    repeat (2) begin
      @(negedge clk);
      check("resume_idle", 32'(value_a), 32'd0);
    end
    @(negedge clk);
    check("resume", 32'(value_a), 32'd1);

    // Custom wrap point sequence
    pulse(1, 3);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("seq_b", 32'(value_b), 32'(seq_tbl[i]));
      @(negedge clk);
    end

    // Random run lengths and reset pulses; release kept off the rising edge
    repeat (30) begin
      cycles(int'($urandom_range(1, 300)));
      d = int'($urandom_range(1, 4));
      h = int'($urandom_range(2, 25));
      if ((d + h) % 10 == 5) h = h + 1;
      pulse(d, h);
    end
    cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
